// File: rtl/byte_lanes_pkg.sv
// ---------------------------------------------------------------------------
// byte_lanes_pkg
//   Shared definitions for the 4-lane byte striper / unstriper pair.
//   Holds the lane count, the idle K character, the width of a lane index
//   and the packed layout of one striped word.
//   A packed word is {DK_3..DK_0, LANE3..LANE0}: the four K flags sit in
//   the upper bits, lane 0 sits in the least significant byte.
//   lane_sel() picks one lane out of a word as {K flag, byte}.
// ---------------------------------------------------------------------------
package byte_lanes_pkg;

  localparam int NUM_LANES  = 4;
  localparam int LANE_IDX_W = 2;
  localparam int WORD_W     = NUM_LANES * 9;

  localparam logic [7:0] K28_5 = 8'hBC;

  typedef struct packed {
    logic [NUM_LANES-1:0]      k;
    logic [NUM_LANES-1:0][7:0] data;
  } lane_word_t;

  // Returns the selected lane as {K flag, data byte}.
  function automatic logic [8:0] lane_sel(input lane_word_t w,
                                          input logic [LANE_IDX_W-1:0] idx);
    return {w.k[idx], w.data[idx]};
  endfunction

endpackage

// File: rtl/unstrip_word_fifo.sv
// ---------------------------------------------------------------------------
// unstrip_word_fifo
//   Small synchronous FIFO holding whole striped words for byte_unstrip.
//   Read data is the head entry, available combinationally while not empty.
//   Ports:
//     CLK, RST_N   clock, asynchronous active-low reset (empties the FIFO)
//     push/wr_data write wr_data at the tail; ignored when full
//     pop          drop the head entry; ignored when empty
//     rd_data      current head entry
//     full/empty   occupancy flags, derived from the registered count
//     count        number of stored entries
// ---------------------------------------------------------------------------
module unstrip_word_fifo
  import byte_lanes_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = WORD_W
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  // Storage has no reset: entries are only ever read once written.
  always_ff @(posedge CLK) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/byte_unstrip.sv
// ---------------------------------------------------------------------------
// byte_unstrip
//   Receive-side companion of the 4-lane byte striper. Each LANES_VALID
//   strobe delivers one 4-lane word; the word is buffered and then sent out
//   one byte per clock, lane 0 first. When nothing is buffered the output
//   carries idle fill (IDLE_BYTE / IDLE_K) with VALID_OUT low.
//   Ports:
//     CLK, RST_N          clock, asynchronous active-low reset
//     LANE0..LANE3        lane bytes of one striped word
//     DK_0..DK_3          K flag for the matching lane
//     LANES_VALID         one-cycle strobe: lanes hold a complete word
//     LANES_READY         buffer has space; a strobe this cycle is accepted
//     D_OUT, DK_OUT       reassembled byte stream and its K flag
//     VALID_OUT           D_OUT/DK_OUT carry real data
//     OVERFLOW            sticky: a strobe arrived while not ready
// ---------------------------------------------------------------------------
module byte_unstrip
  import byte_lanes_pkg::*;
#(
  parameter int         BUF_DEPTH = 2,
  parameter logic [7:0] IDLE_BYTE = K28_5,
  parameter logic       IDLE_K    = 1'b1
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [7:0] LANE0,
  input  logic [7:0] LANE1,
  input  logic [7:0] LANE2,
  input  logic [7:0] LANE3,
  input  logic       DK_0,
  input  logic       DK_1,
  input  logic       DK_2,
  input  logic       DK_3,
  input  logic       LANES_VALID,
  output logic       LANES_READY,
  output logic [7:0] D_OUT,
  output logic       DK_OUT,
  output logic       VALID_OUT,
  output logic       OVERFLOW
);

  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  localparam logic [LANE_IDX_W-1:0] LAST_LANE = LANE_IDX_W'(NUM_LANES - 1);

  logic [0:0]            state;
  logic [LANE_IDX_W-1:0] idx;
  lane_word_t            in_word;
  lane_word_t            head_word;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  logic                  push;
  logic                  pop;
  logic                  more_after_pop;

  assign in_word.k    = {DK_3, DK_2, DK_1, DK_0};
  assign in_word.data = {LANE3, LANE2, LANE1, LANE0};

  // Readiness comes from the registered count only, so a full buffer stays
  // not-ready even in the cycle its head word is being popped.
  assign LANES_READY = ~fifo_full;
  assign push        = LANES_VALID & ~fifo_full;
  assign pop         = (state == ST_SEND) && (idx == LAST_LANE);

  // A word accepted in the popping cycle also keeps SEND going, which is
  // what lets back-to-back words leave without an idle byte between them.
  assign more_after_pop = (fifo_count > CNT_W'(1)) || push;

  unstrip_word_fifo #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .push    (push),
    .wr_data (in_word),
    .pop     (pop),
    .rd_data (head_word),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Sticky overflow flag: only reset clears it.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      OVERFLOW <= 1'b0;
    end else if (LANES_VALID && fifo_full) begin
      OVERFLOW <= 1'b1;
    end
  end

  // Sender FSM plus registered byte mux. IDLE spends one cycle noticing a
  // new word, then SEND walks lanes 0..3 of the head word and pops it on
  // the last lane.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= ST_IDLE;
      idx       <= '0;
      D_OUT     <= IDLE_BYTE;
      DK_OUT    <= IDLE_K;
      VALID_OUT <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          D_OUT     <= IDLE_BYTE;
          DK_OUT    <= IDLE_K;
          VALID_OUT <= 1'b0;
          idx       <= '0;
          if (!fifo_empty) begin
            state <= ST_SEND;
          end
        end
        ST_SEND: begin
          {DK_OUT, D_OUT} <= lane_sel(head_word, idx);
          VALID_OUT       <= 1'b1;
          idx             <= idx + 1'b1;
          if (idx == LAST_LANE) begin
            state <= more_after_pop ? ST_SEND : ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          idx       <= '0;
          D_OUT     <= IDLE_BYTE;
          DK_OUT    <= IDLE_K;
          VALID_OUT <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_byte_unstrip.sv
// ---------------------------------------------------------------------------
// tb_byte_unstrip
//   Testbench for byte_unstrip with BUF_DEPTH = 2. A timeline model predicts
//   for every accepted word the clock edges on which its four bytes appear,
//   and a negedge process compares every output against that prediction.
//   Directed sequences add literal expectations on top.
// ---------------------------------------------------------------------------
module tb_byte_unstrip;

  localparam int         BUF_DEPTH = 2;
  localparam logic [7:0] IDLE_BYTE = 8'hBC;
  localparam logic       IDLE_K    = 1'b1;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [7:0] lane [4];
  logic [3:0] dk;
  logic       lanes_valid;
  logic       lanes_ready;
  logic [7:0] d_out;
  logic       dk_out;
  logic       valid_out;
  logic       overflow;

  int check_count = 0;
  int error_count = 0;
  int edge_num = 0;
  bit check_en = 1'b0;

  // Timeline model state
  int         acc_edge [$];
  int         end_edge [$];
  logic [8:0] exp_byte [int];
  int         last_end = -100;
  bit         ovf_exp  = 1'b0;

  byte_unstrip #(
    .BUF_DEPTH (BUF_DEPTH),
    .IDLE_BYTE (IDLE_BYTE),
    .IDLE_K    (IDLE_K)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .LANE0       (lane[0]),
    .LANE1       (lane[1]),
    .LANE2       (lane[2]),
    .LANE3       (lane[3]),
    .DK_0        (dk[0]),
    .DK_1        (dk[1]),
    .DK_2        (dk[2]),
    .DK_3        (dk[3]),
    .LANES_VALID (lanes_valid),
    .LANES_READY (lanes_ready),
    .D_OUT       (d_out),
    .DK_OUT      (dk_out),
    .VALID_OUT   (valid_out),
    .OVERFLOW    (overflow)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) edge_num <= edge_num + 1;

  // Words held just before edge t: accepted before t, not yet finished.
  function automatic int model_count(input int t);
    int n = 0;
    foreach (acc_edge[i]) begin
      if (acc_edge[i] < t && end_edge[i] >= t) n++;
    end
    return n;
  endfunction

  // Timeline model: a word accepted at edge t starts right after the word
  // ahead of it if that one is still sending at t, else two edges later.
  always @(posedge CLK) begin
    if (RST_N && lanes_valid) begin
      if (model_count(edge_num) < BUF_DEPTH) begin
        int start;
        start = (edge_num <= last_end) ? last_end + 1 : edge_num + 2;
        for (int i = 0; i < 4; i++) begin
          exp_byte[start + i] = {dk[i], lane[i]};
        end
        last_end = start + 3;
        acc_edge.push_back(edge_num);
        end_edge.push_back(start + 3);
      end else begin
        ovf_exp = 1'b1;
      end
    end
  end

  // Reset throws away everything buffered or in flight.
  always @(negedge RST_N) begin
    acc_edge.delete();
    end_edge.delete();
    exp_byte.delete();
    last_end = -100;
    ovf_exp  = 1'b0;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s at t=%0t: got %0h, expected %0h", name, $time,
               actual, expected);
    end
  endtask

  // Per-cycle comparison against the timeline model.
  always @(negedge CLK) begin
    if (check_en) begin
      int         t;
      logic       e_valid;
      logic [8:0] e_kd;
      t = edge_num - 1;
      if (exp_byte.exists(t)) begin
        e_valid = 1'b1;
        e_kd    = exp_byte[t];
      end else begin
        e_valid = 1'b0;
        e_kd    = {IDLE_K, IDLE_BYTE};
      end
      checkOutput("model valid_out", 32'(valid_out), 32'(e_valid));
      checkOutput("model d_out", 32'(d_out), 32'(e_kd[7:0]));
      checkOutput("model dk_out", 32'(dk_out), 32'(e_kd[8]));
      checkOutput("model lanes_ready", 32'(lanes_ready),
                  32'(model_count(t + 1) < BUF_DEPTH));
      checkOutput("model overflow", 32'(overflow), 32'(ovf_exp));
    end
  end

  // Presents one word for exactly one edge; call on a negedge.
  task automatic applyStimulus(input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2, input logic [7:0] b3,
                               input logic [3:0] k);
    lane[0]     = b0;
    lane[1]     = b1;
    lane[2]     = b2;
    lane[3]     = b3;
    dk          = k;
    lanes_valid = 1'b1;
    @(negedge CLK);
    lanes_valid = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic checkIdle(input string name);
    checkOutput({name, " d_out"}, 32'(d_out), 32'(8'hBC));
    checkOutput({name, " dk_out"}, 32'(dk_out), 32'(1'b1));
    checkOutput({name, " valid_out"}, 32'(valid_out), 32'(1'b0));
  endtask

  initial begin
    logic [7:0] seq_a [8];
    int         valid_seen;

    lanes_valid = 1'b0;
    dk          = '0;
    for (int i = 0; i < 4; i++) lane[i] = '0;
    #1;
    check_en = 1'b1;

    // Reset held for 3 clocks, then released with no strobe
    $display("[TB] reset");
    idleCycles(3);
    checkIdle("reset");
    checkOutput("reset lanes_ready", 32'(lanes_ready), 32'(1'b1));
    checkOutput("reset overflow", 32'(overflow), 32'(1'b0));
    RST_N = 1'b1;
    idleCycles(3);
    checkIdle("post-reset");

    // Single word: bytes appear from the second edge after acceptance
    $display("[TB] single word");
    applyStimulus(8'h11, 8'h22, 8'h33, 8'h44, 4'b0000);
    checkIdle("single N");
    idleCycles(1);
    checkIdle("single N+1");
    seq_a = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 4; i++) begin
      idleCycles(1);
      checkOutput("single byte", 32'(d_out), 32'(seq_a[i]));
      checkOutput("single valid", 32'(valid_out), 32'(1'b1));
      checkOutput("single dk", 32'(dk_out), 32'(1'b0));
    end
    idleCycles(1);
    checkIdle("single tail");
    idleCycles(4);

    // Back-to-back words four clocks apart, K flag on B lane 0
    $display("[TB] back-to-back");
    seq_a = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1, 8'hB2, 8'hB3};
    fork
      begin
        applyStimulus(8'hA0, 8'hA1, 8'hA2, 8'hA3, 4'b0000);
        idleCycles(3);
        applyStimulus(8'hB0, 8'hB1, 8'hB2, 8'hB3, 4'b0001);
      end
      begin
        idleCycles(2);
        for (int i = 0; i < 8; i++) begin
          idleCycles(1);
          checkOutput("b2b byte", 32'(d_out), 32'(seq_a[i]));
          checkOutput("b2b valid", 32'(valid_out), 32'(1'b1));
          checkOutput("b2b dk", 32'(dk_out), 32'(i == 4));
        end
        idleCycles(1);
        checkIdle("b2b tail");
      end
    join
    idleCycles(4);

    // Four strobes on consecutive clocks into a two-word buffer
    $display("[TB] overflow");
    valid_seen = 0;
    fork
      begin
        applyStimulus(8'h01, 8'h02, 8'h03, 8'h04, 4'b0000);
        applyStimulus(8'h05, 8'h06, 8'h07, 8'h08, 4'b1000);
        applyStimulus(8'h09, 8'h0A, 8'h0B, 8'h0C, 4'b0000);
        applyStimulus(8'h0D, 8'h0E, 8'h0F, 8'h10, 4'b0000);
      end
      begin
        idleCycles(1);
        checkOutput("ovf ready after 1st", 32'(lanes_ready), 32'(1'b1));
        checkOutput("ovf flag after 1st", 32'(overflow), 32'(1'b0));
        idleCycles(1);
        checkOutput("ovf ready at 3rd", 32'(lanes_ready), 32'(1'b0));
        checkOutput("ovf flag after 2nd", 32'(overflow), 32'(1'b0));
        idleCycles(1);
        checkOutput("ovf flag after 3rd", 32'(overflow), 32'(1'b1));
      end
      begin
        for (int i = 0; i < 16; i++) begin
          idleCycles(1);
          if (valid_out === 1'b1) valid_seen++;
        end
      end
    join
    checkOutput("ovf bytes emitted", 32'(valid_seen), 32'(8));
    checkOutput("ovf flag held", 32'(overflow), 32'(1'b1));
    checkIdle("ovf tail");

    // Reset asserted while lane 1 of a word is on the output
    $display("[TB] reset mid-word");
    applyStimulus(8'h5A, 8'h6B, 8'h7C, 8'h8D, 4'b0000);
    idleCycles(3);
    checkOutput("midrst lane1", 32'(d_out), 32'(8'h6B));
    #1 RST_N = 1'b0;
    #1;
    checkIdle("midrst immediate");
    checkOutput("midrst overflow", 32'(overflow), 32'(1'b0));
    checkOutput("midrst ready", 32'(lanes_ready), 32'(1'b1));
    idleCycles(2);
    RST_N = 1'b1;
    valid_seen = 0;
    for (int i = 0; i < 8; i++) begin
      idleCycles(1);
      if (valid_out === 1'b1) valid_seen++;
    end
    checkOutput("midrst no leftovers", 32'(valid_seen), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", check_count,
             error_count);
    $finish;
  end

endmodule
